dmem_arbiter: RTL and testbench

//  Shares the single data_mem port between the CPU (port 0) and an auxiliary master (port 1, debug/boot loader).

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_rr.sv | 24 ++
 rtl/dmem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
// Pure declarations, no logic, no latency.
// No flow control here; the arbiter and the picker import these names.
package dmem_arb_pkg;

  // Access sequencer states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Requester ids; also the encoding of the last-grant bit
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arb_rr.sv
// 2-way round-robin picker: chooses which requester owns the next access.
// Purely combinational, zero latency.
// No backpressure; the caller only samples the result while idle.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // A lone requester always wins; a tie goes to whoever did not win last time
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = PORT_AUX;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data_mem port between the CPU (port 0) and an aux master (port 1), one access at a time.
// Latency: request sampled in IDLE at edge N gives ready in cycle N+3, plus 1 per mem_busy cycle.
// Backpressure: requesters hold req until ready; mem_busy holds WAIT, which a watchdog bounds. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WDOG_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_mask,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // aux port
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [2:0]        aux_mask,
  output logic              aux_ready,
  output logic [DATA_W-1:0] aux_rdata,
  // completion status
  output logic              err,
  // data_mem side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [2:0]        mem_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [7:0]        abort_cnt
`endif
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(MAX_WAIT);

  arb_state_e        r_state;
  arb_state_e        w_next_state;

  logic              r_last_gnt;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_mask;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_abort;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_aux_rdata;

  logic [1:0]        w_req;
  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_grant;
  logic              w_strobe;
  logic              w_resp;
  logic              w_wdog_hit;
  logic              w_capture;

  assign w_req      = {aux_req, cpu_req};
  assign w_wdog_hit = (r_wdog == WDOG_LIMIT);

  dmem_arb_rr u_rr (
    .req       (w_req),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // State register; reset drops straight to IDLE so strobes fall without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-state strobe/response qualifiers
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_strobe     = 1'b0;
    w_resp       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_grant      = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_strobe     = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_strobe = 1'b1;
        // Completion wins over the watchdog if both happen in the same cycle
        if (!mem_busy) begin
          w_capture    = ~r_we;
          w_next_state = ST_RESP;
        end else if (w_wdog_hit) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's command at the grant edge; later input changes cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= PORT_AUX;
      r_win      <= PORT_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
    end else if (w_grant) begin
      r_last_gnt <= w_gnt_id;
      r_win      <= w_gnt_id;
      if (w_gnt_id == PORT_AUX) begin
        r_we    <= aux_we;
        r_addr  <= aux_addr;
        r_wdata <= aux_wdata;
        r_mask  <= aux_mask;
      end else begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_mask  <= cpu_mask;
      end
    end
  end

  // Watchdog: cleared on issue, counts busy cycles in WAIT, stops at the limit and flags an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog  <= '0;
      r_abort <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      r_wdog  <= '0;
      r_abort <= 1'b0;
    end else if (r_state == ST_WAIT && mem_busy) begin
      if (w_wdog_hit) begin
        r_abort <= 1'b1;
      end else begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
    end
  end

  // Read data lands only in the winner's register and only for reads that really completed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata <= '0;
      r_aux_rdata <= '0;
    end else if (w_capture) begin
      if (r_win == PORT_AUX) begin
        r_aux_rdata <= mem_rdata;
      end else begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign mem_mask     = r_mask;
  assign mem_memread  = w_strobe & ~r_we;
  assign mem_memwrite = w_strobe & r_we;

  assign cpu_ready = w_resp & (r_win == PORT_CPU);
  assign aux_ready = w_resp & (r_win == PORT_AUX);
  assign err       = w_resp & r_abort;
  assign cpu_rdata = r_cpu_rdata;
  assign aux_rdata = r_aux_rdata;
  // Used upstream to gate the processor clock while its access is pending
  assign cpu_stall = cpu_req & ~cpu_ready;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;
  logic [7:0]  r_abort_cnt;

  // Saturating per-port completion and abort counters, advanced once per response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt0  <= '0;
      r_gnt_cnt1  <= '0;
      r_abort_cnt <= '0;
    end else if (w_resp) begin
      if (r_win == PORT_CPU && r_gnt_cnt0 != 16'hFFFF) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      end
      if (r_win == PORT_AUX && r_gnt_cnt1 != 16'hFFFF) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
      end
      if (r_abort && r_abort_cnt != 8'hFF) begin
        r_abort_cnt <= r_abort_cnt + 8'd1;
      end
    end
  end

  assign gnt_cnt0  = r_gnt_cnt0;
  assign gnt_cnt1  = r_gnt_cnt1;
  assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset values, latency, round-robin order, busy stretch, watchdog abort, mid-access reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Every check goes through chk, which counts it and prints a FAIL line on mismatch.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [2:0]  cpu_mask, aux_mask;
  logic        cpu_ready, cpu_stall, aux_ready, err;
  logic [31:0] cpu_rdata, aux_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memread, mem_memwrite, mem_busy;
  logic [2:0]  mem_mask;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  logic [7:0]  abort_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WDOG_W(8), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mask(cpu_mask), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_mask(aux_mask), .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .abort_cnt(abort_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_mask = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0; aux_mask = '0;
    mem_rdata = '0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Count cycles until the given port's ready pulse; limit bounds the wait
  task automatic wait_ready(input logic port, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(port ? aux_ready : cpu_ready) && n < limit);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_memread", mem_memread, 0);
    chk("rst_memwrite", mem_memwrite, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    rst_n = 1'b1;
    tick();

    // Simultaneous requests right after reset: CPU first, then strict alternation
    cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
    aux_req = 1'b1; aux_addr = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      mem_rdata = 32'hA5A5_0000 + 32'(g);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!(cpu_ready || aux_ready) && cyc < 20);
      chk("rr_latency", cyc, (g == 0) ? 3 : 4);
      chk("rr_grant_port", aux_ready, g % 2);
      chk("rr_rdata", aux_ready ? aux_rdata : cpu_rdata, 32'hA5A5_0000 + 32'(g));
    end
    cpu_req = 1'b0; aux_req = 1'b0;

    do_reset();

    // Single CPU read, zero-wait memory; address change and req drop after grant are ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_mask = 3'b100;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_issue_memread", mem_memread, 1);
    chk("rd_issue_memwrite", mem_memwrite, 0);
    chk("rd_issue_addr", mem_addr, 32'h0000_1000);
    chk("rd_issue_mask", mem_mask, 3'b100);
    chk("rd_stall", cpu_stall, 1);
    chk("rd_issue_ready", cpu_ready, 0);
    cpu_addr = 32'hFFFF_0000; cpu_req = 1'b0;
    tick();
    chk("rd_wait_memread", mem_memread, 1);
    chk("rd_wait_addr", mem_addr, 32'h0000_1000);
    tick();
    chk("rd_ready", cpu_ready, 1);
    chk("rd_resp_memread", mem_memread, 0);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_err", err, 0);
    tick();
    chk("rd_ready_pulse", cpu_ready, 0);

    // Aux write with five busy cycles; read data on the bus must be ignored
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h0000_2004; aux_wdata = 32'h1234_5678;
    aux_mask = 3'b010; mem_busy = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("wr_issue_memwrite", mem_memwrite, 1);
    chk("wr_issue_memread", mem_memread, 0);
    chk("wr_issue_mask", mem_mask, 3'b010);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wr_hold_memwrite", mem_memwrite, 1);
      chk("wr_hold_addr", mem_addr, 32'h0000_2004);
      chk("wr_hold_wdata", mem_wdata, 32'h1234_5678);
      chk("wr_hold_ready", aux_ready, 0);
      if (i == 5) mem_busy = 1'b0;
    end
    tick();
    chk("wr_ready", aux_ready, 1);
    chk("wr_err", err, 0);
    chk("wr_aux_rdata", aux_rdata, 0);
    chk("wr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("wr_resp_memwrite", mem_memwrite, 0);
    aux_req = 1'b0; aux_we = 1'b0;

    // Memory stuck busy: watchdog aborts after MAX_WAIT busy cycles
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000;
    mem_busy = 1'b1; mem_rdata = 32'h0BAD_F00D;
    wait_ready(1'b0, 400, cyc);
    chk("wd_latency", cyc, MAX_WAIT + 3);
    chk("wd_err", err, 1);
    chk("wd_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    mem_busy = 1'b0; mem_rdata = 32'h1357_9BDF;
    tick();
    chk("wd_err_pulse", err, 0);
    cpu_req = 1'b1;
    wait_ready(1'b0, 20, cyc);
    chk("wd_next_latency", cyc, 3);
    chk("wd_next_err", err, 0);
    chk("wd_next_rdata", cpu_rdata, 32'h1357_9BDF);
    cpu_req = 1'b0;

    // Aux read with req dropped during ISSUE still completes
    tick();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h0000_4000; mem_rdata = 32'h2468_ACE0;
    tick();
    aux_req = 1'b0;
    wait_ready(1'b1, 20, cyc);
    chk("drop_latency", cyc, 2);
    chk("drop_aux_rdata", aux_rdata, 32'h2468_ACE0);
    chk("drop_cpu_rdata", cpu_rdata, 32'h1357_9BDF);
    tick();

`ifdef DMEM_ARB_STATS_EN
    chk("stats_gnt0", gnt_cnt0, 3);
    chk("stats_gnt1", gnt_cnt1, 2);
    chk("stats_abort", abort_cnt, 1);
`endif

    // Reset in the middle of WAIT: strobes drop at once, no response, clean restart
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5000; mem_busy = 1'b1;
    tick();
    tick();
    chk("mrst_wait_memread", mem_memread, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_async_memread", mem_memread, 0);
    chk("mrst_async_memwrite", mem_memwrite, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_ready", cpu_ready, 0);
      chk("mrst_no_err", err, 0);
    end
    rst_n = 1'b1; mem_busy = 1'b0; mem_rdata = 32'h55AA_55AA;
    wait_ready(1'b0, 20, cyc);
    chk("mrst_fresh_latency", cyc, 3);
    chk("mrst_fresh_rdata", cpu_rdata, 32'h55AA_55AA);
    chk("mrst_fresh_err", err, 0);
    cpu_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
